// File: rtl/byte_mem_if.sv
// Request/response bus of the byte-addressed memory controller.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. While a
// response is presented and not taken, every rsp_* signal stays stable. A
// master must not make req_* depend combinationally on req_ready.
interface byte_mem_if #(
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [63:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_data;
  logic              rsp_write;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_write, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_write, rsp_err
  );
endinterface

// File: rtl/byte_mem_ctrl.sv
// Byte-addressed register-file memory with 1/2/4/8-byte little-endian
// accesses, wrap-around addressing, optional alignment checking and a
// single-entry response register (one-cycle latency, one outstanding).
module byte_mem_ctrl #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int INIT_MODE    = 1,
  parameter int STRICT_ALIGN = 0
) (
  input  logic       clk,
  input  logic       reset,
  byte_mem_if.slave  bus,
  output logic [0:0] state_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  logic [7:0]        mem_q [DEPTH];
  logic [0:0]        state_q, state_d;
  logic [63:0]       rsp_data_q, rsp_data_d;
  logic              rsp_write_q, rsp_write_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept;
  logic              misalign;
  logic [7:0]        byte_en;
  logic [ADDR_W-1:0] idx [8];
  logic [63:0]       rd_data;

  // A new request fits whenever the response slot is empty or being drained.
  assign bus.req_ready = ((state_q == ST_IDLE) || bus.rsp_ready) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  // Decode access size into byte lanes and the alignment check.
  always_comb begin
    byte_en  = 8'h01;
    misalign = 1'b0;
    case (bus.req_size)
      2'b00:   begin byte_en = 8'h01; misalign = 1'b0;                  end
      2'b01:   begin byte_en = 8'h03; misalign = bus.req_addr[0];       end
      2'b10:   begin byte_en = 8'h0F; misalign = |bus.req_addr[1:0];    end
      default: begin byte_en = 8'hFF; misalign = |bus.req_addr[2:0];    end
    endcase
    if (STRICT_ALIGN == 0) misalign = 1'b0;
  end

  // Per-lane byte address (truncation to ADDR_W gives the wrap) and read gather.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < 8; k++) begin
      idx[k] = bus.req_addr + ADDR_W'(k);
      if (byte_en[k]) rd_data[8*k +: 8] = mem_q[idx[k]];
    end
  end

  // Response slot next state: load on accept, empty when drained, else hold.
  always_comb begin
    state_d     = state_q;
    rsp_data_d  = rsp_data_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      state_d     = ST_RESP;
      rsp_write_d = bus.req_write;
      rsp_err_d   = misalign;
      rsp_data_d  = (bus.req_write || misalign) ? 64'h0 : rd_data;
    end else if (bus.rsp_ready) begin
      state_d = ST_IDLE;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rsp_data_q  <= '0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_data_q  <= rsp_data_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage: whole-array init on reset, byte-lane scatter on an accepted write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (INIT_MODE == 1) ? 8'(i) : 8'h00;
      end
    end else if (accept && bus.req_write && !misalign) begin
      for (int k = 0; k < 8; k++) begin
        if (byte_en[k]) mem_q[idx[k]] <= bus.req_wdata[8*k +: 8];
      end
    end
  end

  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_err   = rsp_err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Bench for byte_mem_ctrl. Three instances share one stimulus stream:
//   a: DEPTH=16, INIT_MODE=1, STRICT_ALIGN=0 (defaults)
//   b: DEPTH=16, INIT_MODE=1, STRICT_ALIGN=1
//   c: DEPTH=32, INIT_MODE=0, STRICT_ALIGN=0
// A byte-array model per instance predicts every response.
module tb_byte_mem_ctrl;

  typedef struct packed {
    logic        write;
    logic        err;
    logic [63:0] data;
  } rsp_t;
  typedef rsp_t [2:0] rsp3_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [4:0]  req_addr  = '0;
  logic [1:0]  req_size  = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;

  byte_mem_if #(.ADDR_W(4)) bus_a ();
  byte_mem_if #(.ADDR_W(4)) bus_b ();
  byte_mem_if #(.ADDR_W(5)) bus_c ();

  logic [0:0] st_a, st_b, st_c;

  byte_mem_ctrl #(.DEPTH(16), .ADDR_W(4), .INIT_MODE(1), .STRICT_ALIGN(0)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave), .state_o(st_a));
  byte_mem_ctrl #(.DEPTH(16), .ADDR_W(4), .INIT_MODE(1), .STRICT_ALIGN(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave), .state_o(st_b));
  byte_mem_ctrl #(.DEPTH(32), .ADDR_W(5), .INIT_MODE(0), .STRICT_ALIGN(0)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c.slave), .state_o(st_c));

  assign bus_a.req_valid = req_valid;
  assign bus_a.req_write = req_write;
  assign bus_a.req_addr  = req_addr[3:0];
  assign bus_a.req_size  = req_size;
  assign bus_a.req_wdata = req_wdata;
  assign bus_a.rsp_ready = rsp_ready;
  assign bus_b.req_valid = req_valid;
  assign bus_b.req_write = req_write;
  assign bus_b.req_addr  = req_addr[3:0];
  assign bus_b.req_size  = req_size;
  assign bus_b.req_wdata = req_wdata;
  assign bus_b.rsp_ready = rsp_ready;
  assign bus_c.req_valid = req_valid;
  assign bus_c.req_write = req_write;
  assign bus_c.req_addr  = req_addr;
  assign bus_c.req_size  = req_size;
  assign bus_c.req_wdata = req_wdata;
  assign bus_c.rsp_ready = rsp_ready;

  logic        o_ready [3];
  logic        o_valid [3];
  logic        o_write [3];
  logic        o_err   [3];
  logic [63:0] o_data  [3];

  assign o_ready[0] = bus_a.req_ready;
  assign o_valid[0] = bus_a.rsp_valid;
  assign o_write[0] = bus_a.rsp_write;
  assign o_err[0]   = bus_a.rsp_err;
  assign o_data[0]  = bus_a.rsp_data;
  assign o_ready[1] = bus_b.req_ready;
  assign o_valid[1] = bus_b.rsp_valid;
  assign o_write[1] = bus_b.rsp_write;
  assign o_err[1]   = bus_b.rsp_err;
  assign o_data[1]  = bus_b.rsp_data;
  assign o_ready[2] = bus_c.req_ready;
  assign o_valid[2] = bus_c.rsp_valid;
  assign o_write[2] = bus_c.rsp_write;
  assign o_err[2]   = bus_c.rsp_err;
  assign o_data[2]  = bus_c.rsp_data;

  // ---------------- scoreboard / model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mdl [3][32];
  rsp3_t       exp_q[$];

  function automatic int depth_of(input int d);
    return (d == 2) ? 32 : 16;
  endfunction

  function automatic bit strict_of(input int d);
    return (d == 1);
  endfunction

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d]: observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 32; i++)
        mdl[d][i] = (d == 2) ? 8'h00 : 8'(i);
    exp_q.delete();
  endtask

  // One N-byte access on instance d: returns the response it must produce.
  task automatic model_access(input int d, input logic w, input logic [4:0] a,
                              input logic [1:0] sz, input logic [63:0] wd, output rsp_t r);
    int n, base, p;
    n      = 1 << sz;
    base   = int'(a) % depth_of(d);
    r.write = w;
    r.err   = strict_of(d) && ((base % n) != 0);
    r.data  = '0;
    if (!r.err) begin
      for (int k = 0; k < n; k++) begin
        p = (base + k) % depth_of(d);
        if (w) mdl[d][p] = wd[8*k +: 8];
        else   r.data[8*k +: 8] = mdl[d][p];
      end
    end
  endtask

  task automatic check_rsp();
    rsp3_t e;
    rsp_t  r;
    for (int d = 0; d < 3; d++) begin
      chk("rsp_valid", d, 64'(o_valid[d]), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        r = e[d];
        chk("rsp_data",  d, o_data[d], r.data);
        chk("rsp_write", d, 64'(o_write[d]), 64'(r.write));
        chk("rsp_err",   d, 64'(o_err[d]), 64'(r.err));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; leaves at the next posedge+1 with outputs checked.
  task automatic step(input logic v, input logic w, input logic [4:0] a,
                      input logic [1:0] sz, input logic [63:0] wd, input logic rr);
    logic  exp_ready;
    rsp3_t e;
    rsp_t  r;
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_size  = sz;
    req_wdata = wd;
    rsp_ready = rr;
    #1;
    exp_ready = !reset && ((exp_q.size() == 0) || rr);
    for (int d = 0; d < 3; d++) chk("req_ready", d, 64'(o_ready[d]), 64'(exp_ready));
    if ((exp_q.size() != 0) && rr) void'(exp_q.pop_front());
    if (v && exp_ready) begin
      for (int d = 0; d < 3; d++) begin
        model_access(d, w, a, sz, wd, r);
        e[d] = r;
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    check_rsp();
  endtask

  task automatic do_reset(input logic v, input logic rr);
    reset     = 1'b1;
    req_valid = v;
    req_write = 1'b1;
    req_addr  = 5'd1;
    req_size  = 2'b00;
    req_wdata = 64'h55;
    rsp_ready = rr;
    #1;
    for (int d = 0; d < 3; d++) chk("req_ready_in_reset", d, 64'(o_ready[d]), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      chk("reset_rsp_valid", d, 64'(o_valid[d]), 64'h0);
      chk("reset_rsp_data",  d, o_data[d], 64'h0);
      chk("reset_rsp_write", d, 64'(o_write[d]), 64'h0);
      chk("reset_rsp_err",   d, 64'(o_err[d]), 64'h0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset(1'b1, 1'b1);

    // 4-byte read inside the array
    step(1'b1, 1'b0, 5'd3, 2'b10, 64'h0, 1'b1);
    chk("read4_addr3", 0, o_data[0], 64'h0000_0000_0605_0403);
    chk("read4_addr3_err", 0, 64'(o_err[0]), 64'h0);

    // 8-byte read wrapping over the top of a 16-byte array
    step(1'b1, 1'b0, 5'd14, 2'b11, 64'h0, 1'b1);
    chk("read8_wrap", 0, o_data[0], 64'h0504_0302_0100_0F0E);

    // wrapping 2-byte write, then read-back on the following edge
    step(1'b1, 1'b1, 5'd15, 2'b01, 64'hBEEF, 1'b1);
    chk("write_rsp_data", 0, o_data[0], 64'h0);
    chk("write_rsp_write", 0, 64'(o_write[0]), 64'h1);
    step(1'b1, 1'b0, 5'd15, 2'b01, 64'h0, 1'b1);
    chk("readback_wrap", 0, o_data[0], 64'hBEEF);
    step(1'b1, 1'b0, 5'd0, 2'b00, 64'h0, 1'b1);
    chk("mem0_after_wrap", 0, o_data[0], 64'hBE);
    step(1'b1, 1'b0, 5'd15, 2'b00, 64'h0, 1'b1);
    chk("mem15_after_wrap", 0, o_data[0], 64'hEF);

    // backpressure: response held three cycles, then back-to-back accept
    step(1'b1, 1'b0, 5'd5, 2'b00, 64'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 5'd9, 2'b00, 64'h0, 1'b0);
      chk("held_data", 0, o_data[0], 64'h05);
    end
    step(1'b1, 1'b0, 5'd6, 2'b00, 64'h0, 1'b1);
    chk("back_to_back", 0, o_data[0], 64'h06);
    chk("back_to_back_valid", 0, 64'(o_valid[0]), 64'h1);

    // strict alignment: misaligned write rejected, memory untouched
    step(1'b1, 1'b1, 5'd2, 2'b10, 64'hFFFF_FFFF, 1'b1);
    chk("misaligned_err", 1, 64'(o_err[1]), 64'h1);
    chk("misaligned_data", 1, o_data[1], 64'h0);
    chk("lax_no_err", 0, 64'(o_err[0]), 64'h0);
    step(1'b1, 1'b0, 5'd0, 2'b11, 64'h0, 1'b1);
    chk("strict_mem_intact", 1, o_data[1], 64'h0706_0504_0302_0100);

    // zero-init instance: write, reset while the response is pending
    step(1'b1, 1'b1, 5'd20, 2'b00, 64'hAA, 1'b0);
    do_reset(1'b1, 1'b0);
    step(1'b1, 1'b0, 5'd20, 2'b00, 64'h0, 1'b1);
    chk("zero_init_after_reset", 2, o_data[2], 64'h0);
    chk("init_after_reset", 0, o_data[0], 64'h04);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
             {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
      end
    end

    // drain
    step(1'b0, 1'b0, 5'd0, 2'b00, 64'h0, 1'b1);
    step(1'b0, 1'b0, 5'd0, 2'b00, 64'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
